// File: rtl/tx_pkg.sv
// Shared definitions for the piso_frame_tx serial transmitter.
//   - State codes: the four base states use a 2-bit Gray-style code
//     (IDLE/START/DATA/STOP); PARITY takes the third state bit so the
//     base codes stay unchanged whether or not parity is enabled.
//   - frame_len(): clocks occupied by one frame for a given configuration.
package tx_pkg;

    localparam logic [1:0] IDLE_CODE   = 2'b00;
    localparam logic [1:0] START_CODE  = 2'b01;
    localparam logic [1:0] DATA_CODE   = 2'b11;
    localparam logic [1:0] STOP_CODE   = 2'b10;
    localparam logic [2:0] PARITY_CODE = 3'b100;

    typedef enum logic [2:0] {
        IDLE   = {1'b0, IDLE_CODE},
        START  = {1'b0, START_CODE},
        DATA   = {1'b0, DATA_CODE},
        STOP   = {1'b0, STOP_CODE},
        PARITY = PARITY_CODE
    } tx_state_e;

    // Clocks per frame: start + data + optional parity + stop bits.
    function automatic int unsigned frame_len(
        input int unsigned n,
        input int unsigned baud_div,
        input int unsigned parity_en,
        input int unsigned stop_bits
    );
        return (1 + n + parity_en + stop_bits) * baud_div;
    endfunction

endpackage

// File: rtl/piso_frame_tx_baud_tick_gen.sv
// Bit-period timer for piso_frame_tx.
// Down-counter that reloads BAUD_DIV-1 on load_i and otherwise counts
// down to 0 and holds there. bit_end_o is high while the count is 0,
// i.e. during the last clock of the current serial bit.
// Ports:
//   clk       - clock, rising edge
//   rst_n     - asynchronous active-low reset (count cleared to 0)
//   load_i    - reload strobe, start of a new bit
//   bit_end_o - current bit ends this clock
module baud_tick_gen #(
    parameter int BAUD_DIV = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    output logic bit_end_o
);

    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] RELOAD = CW'(BAUD_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = RELOAD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_end_o = (cnt_q == '0);

endmodule

// File: rtl/piso_frame_tx.sv
// Parallel-in, serial-out framed transmitter.
// Accepts an N-bit word on a valid/ready handshake and sends one frame:
// start bit (0), N data bits, optional even-parity bit, STOP_BITS stop
// bits (1). Every bit lasts BAUD_DIV clocks. With MSB_FIRST=1 the word
// lands correctly in a shift-left (din into LSB) receiver.
// Ports:
//   clk       - clock, rising edge
//   rst_n     - asynchronous active-low reset
//   din       - parallel word, sampled only at acceptance
//   din_valid - din is valid
//   din_ready - word can be accepted (state is IDLE), combinational
//   tx        - serial line, registered, idles high
//   busy      - frame in progress
//   done      - pulse during the last clock of the final stop bit
//
// state  | meaning
// IDLE   | line high, waiting for a word
// START  | sending start bit (0)
// DATA   | sending data bits, bit counter 0..N-1
// PARITY | sending even-parity bit
// STOP   | sending stop bits, bit counter 0..STOP_BITS-1
module piso_frame_tx
    import tx_pkg::*;
#(
    parameter int N         = 8,
    parameter int BAUD_DIV  = 16,
    parameter int MSB_FIRST = 1,
    parameter int PARITY_EN = 0,
    parameter int STOP_BITS = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] din,
    input  logic         din_valid,
    output logic         din_ready,
    output logic         tx,
    output logic         busy,
    output logic         done
);

    localparam int CNT_W = $clog2(N + 1);
    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] LAST_STOP = CNT_W'(STOP_BITS - 1);

    tx_state_e        state_q, state_d;
    logic [N-1:0]     shift_q, shift_d;
    logic             par_q, par_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             tx_q, tx_d;
    logic             baud_load;
    logic             bit_end;
    logic             done_c;

    baud_tick_gen #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (baud_load),
        .bit_end_o (bit_end)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        par_d     = par_q;
        bit_cnt_d = bit_cnt_q;
        baud_load = 1'b0;
        done_c    = 1'b0;

        case (state_q)
            IDLE: begin
                if (din_valid) begin
                    state_d   = START;
                    shift_d   = din;
                    par_d     = ^din;
                    bit_cnt_d = '0;
                    baud_load = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                    baud_load = 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_load = 1'b1;
                    if (MSB_FIRST != 0) begin
                        shift_d = shift_q << 1;
                    end else begin
                        shift_d = shift_q >> 1;
                    end
                    if (bit_cnt_q == LAST_DATA) begin
                        bit_cnt_d = '0;
                        if (PARITY_EN != 0) begin
                            state_d = PARITY;
                        end else begin
                            state_d = STOP;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d   = STOP;
                    bit_cnt_d = '0;
                    baud_load = 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (bit_cnt_q == LAST_STOP) begin
                        state_d   = IDLE;
                        bit_cnt_d = '0;
                        done_c    = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        baud_load = 1'b1;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                bit_cnt_d = '0;
            end
        endcase

        // tx is registered from the next state so the line changes on the
        // same edge the state does, i.e. only at bit boundaries.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = (MSB_FIRST != 0) ? shift_d[N-1] : shift_d[0];
            PARITY:  tx_d = par_d;
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            par_q     <= 1'b0;
            bit_cnt_q <= '0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
        end
    end

    assign din_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign done      = done_c;
    assign tx        = tx_q;

endmodule

// File: tb/tb_piso_frame_tx.sv
// Bench for piso_frame_tx. Three instances:
//   0: N=8 BAUD_DIV=4 MSB first, no parity, 1 stop
//   1: N=8 BAUD_DIV=4 LSB first, even parity, 1 stop
//   2: N=8 BAUD_DIV=2 MSB first, no parity, 2 stops
// A frame model expands each accepted word into its per-clock tx list and
// is compared against every instance on every falling edge; directed
// frames with literal bit patterns pin the model.
module tb_piso_frame_tx;

    logic            clk;
    logic            rst_n;
    logic [2:0][7:0] din_v;
    logic [2:0]      dv_v;
    logic [2:0]      rdy_w, tx_w, busy_w, done_w;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    bit checks_on = 0;

    logic exp_bits [3][64];
    int   exp_len  [3];
    int   exp_pos  [3];

    piso_frame_tx #(.N(8), .BAUD_DIV(4), .MSB_FIRST(1), .PARITY_EN(0), .STOP_BITS(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .din(din_v[0]), .din_valid(dv_v[0]),
        .din_ready(rdy_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .done(done_w[0]));

    piso_frame_tx #(.N(8), .BAUD_DIV(4), .MSB_FIRST(0), .PARITY_EN(1), .STOP_BITS(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .din(din_v[1]), .din_valid(dv_v[1]),
        .din_ready(rdy_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .done(done_w[1]));

    piso_frame_tx #(.N(8), .BAUD_DIV(2), .MSB_FIRST(1), .PARITY_EN(0), .STOP_BITS(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .din(din_v[2]), .din_valid(dv_v[2]),
        .din_ready(rdy_w[2]), .tx(tx_w[2]), .busy(busy_w[2]), .done(done_w[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    // Expand a word into the list of line levels, one entry per clock.
    function automatic void build_frame(input int i, input logic [7:0] w);
        logic bits [16];
        int   nb;
        int   baud;
        bit   msb, par;
        int   stops;
        case (i)
            0:       begin baud = 4; msb = 1; par = 0; stops = 1; end
            1:       begin baud = 4; msb = 0; par = 1; stops = 1; end
            default: begin baud = 2; msb = 1; par = 0; stops = 2; end
        endcase
        nb = 0;
        bits[nb++] = 1'b0;
        for (int j = 0; j < 8; j++) bits[nb++] = msb ? w[7-j] : w[j];
        if (par) bits[nb++] = ^w;
        for (int j = 0; j < stops; j++) bits[nb++] = 1'b1;
        exp_len[i] = 0;
        for (int b = 0; b < nb; b++)
            for (int c = 0; c < baud; c++) exp_bits[i][exp_len[i]++] = bits[b];
        exp_pos[i] = 0;
    endfunction

    // Model: a word is taken whenever the model is idle and valid is high.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                exp_len[i] = 0;
                exp_pos[i] = 0;
            end else if (exp_pos[i] >= exp_len[i]) begin
                if (dv_v[i]) build_frame(i, din_v[i]);
            end else begin
                exp_pos[i]++;
            end
        end
    end

    always @(negedge clk) begin
        if (checks_on) begin
            for (int i = 0; i < 3; i++) begin
                bit   idle;
                logic e_tx, e_done;
                idle   = !rst_n || (exp_pos[i] >= exp_len[i]);
                e_tx   = idle ? 1'b1 : exp_bits[i][exp_pos[i]];
                e_done = !idle && (exp_pos[i] == exp_len[i] - 1);
                chk($sformatf("model_tx[%0d]", i),    32'(tx_w[i]),   32'(e_tx));
                chk($sformatf("model_ready[%0d]", i), 32'(rdy_w[i]),  32'(idle));
                chk($sformatf("model_busy[%0d]", i),  32'(busy_w[i]), 32'(!idle));
                chk($sformatf("model_done[%0d]", i),  32'(done_w[i]), 32'(e_done));
            end
        end
    end

    // Send one word (caller is just after a rising edge, instance idle) and
    // check the frame against a literal bit list, first bit in lit[nb-1].
    task automatic literal_frame(input int i, input logic [7:0] w, input logic [15:0] lit,
                                 input int nb, input int baud, input string nm);
        din_v[i] = w;
        dv_v[i]  = 1'b1;
        @(negedge clk);
        chk({nm, "_ready_pre"}, 32'(rdy_w[i]), 32'd1);
        @(posedge clk);
        #1 dv_v[i] = 1'b0;
        for (int b = 0; b < nb; b++) begin
            for (int c = 0; c < baud; c++) begin
                @(negedge clk);
                chk($sformatf("%s_tx_b%0d", nm, b), 32'(tx_w[i]), 32'(lit[nb-1-b]));
                chk($sformatf("%s_done_b%0d_c%0d", nm, b, c), 32'(done_w[i]),
                    32'((b == nb - 1) && (c == baud - 1)));
                chk($sformatf("%s_busy", nm), 32'(busy_w[i]), 32'd1);
            end
        end
        @(negedge clk);
        chk({nm, "_ready_post"}, 32'(rdy_w[i]), 32'd1);
        chk({nm, "_tx_post"}, 32'(tx_w[i]), 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int d, s;
        rst_n = 1'b1;
        din_v = '0;
        dv_v  = '0;
        #1 rst_n = 1'b0;
        #1 checks_on = 1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Idle after reset.
        repeat (20) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("idle_tx[%0d]", i),    32'(tx_w[i]),   32'd1);
                chk($sformatf("idle_ready[%0d]", i), 32'(rdy_w[i]),  32'd1);
                chk($sformatf("idle_busy[%0d]", i),  32'(busy_w[i]), 32'd0);
                chk($sformatf("idle_done[%0d]", i),  32'(done_w[i]), 32'd0);
            end
        end
        @(posedge clk);
        #1;

        // C4, MSB first: 0 11000100 1, 40 clocks.
        literal_frame(0, 8'hC4, 16'(10'b0110001001), 10, 4, "msb_c4");
        // C4, LSB first + parity: 0 00100011 1 1, 44 clocks.
        literal_frame(1, 8'hC4, 16'(11'b00010001111), 11, 4, "lsb_par_c4");
        // FF, 2 stop bits, BAUD_DIV 2: 22 clocks.
        literal_frame(2, 8'hFF, 16'(11'b01111111111), 11, 2, "stop2_ff");
        literal_frame(0, 8'h5A, 16'(10'b0010110101), 10, 4, "msb_5a");

        // Back-to-back with valid held; din disturbed mid-frame.
        din_v[0] = 8'hC4;
        dv_v[0]  = 1'b1;
        d = -1;
        s = -1;
        for (int c = 0; c < 200 && s < 0; c++) begin
            @(negedge clk);
            if (c == 10) din_v[0] = 8'hFF;
            if (c == 20) din_v[0] = 8'h0F;
            if (done_w[0] && d < 0) d = c;
            else if (d >= 0 && !tx_w[0]) s = c;
        end
        dv_v[0] = 1'b0;
        chk("b2b_found_done", 32'(d >= 0), 32'd1);
        chk("b2b_gap", 32'(s - d), 32'd2);
        repeat (45) @(negedge clk);
        chk("b2b_idle_after", 32'(rdy_w[0]), 32'd1);
        @(posedge clk);
        #1;

        // Reset at clock 13 of a frame.
        din_v[0] = 8'hC4;
        dv_v[0]  = 1'b1;
        @(posedge clk);
        #1 dv_v[0] = 1'b0;
        repeat (13) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_tx",    32'(tx_w[0]),   32'd1);
        chk("rst_busy",  32'(busy_w[0]), 32'd0);
        chk("rst_done",  32'(done_w[0]), 32'd0);
        chk("rst_ready", 32'(rdy_w[0]),  32'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        literal_frame(0, 8'h0F, 16'(10'b0000011111), 10, 4, "post_rst_0f");

        repeat (5) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
